// File: rtl/float_sqrt_param.sv
// Parametrised IEEE-754 square root with stb/ack handshakes, denormal support,
// round-to-nearest-even and invalid/inexact flags. One operation in flight.
module float_sqrt_param #(
  parameter int unsigned EXP_W  = 11,
  parameter int unsigned FRAC_W = 52
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EXP_W+FRAC_W:0]   input_a,
  input  logic                    input_a_stb,
  output logic                    input_a_ack,
  output logic [EXP_W+FRAC_W:0]   output_z,
  output logic                    output_z_stb,
  input  logic                    output_z_ack,
  output logic                    output_invalid,
  output logic                    output_inexact
);

  localparam int unsigned W  = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW = FRAC_W + 2;  // mantissa incl. room for the odd-exponent shift
  localparam int unsigned EW = EXP_W + 2;   // signed unbiased exponent, covers denormal range
  localparam int unsigned RW = FRAC_W + 5;  // partial remainder
  localparam int unsigned CW = $clog2(FRAC_W + 3);
  localparam logic [EW-1:0] Bias = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0]  QNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StGetA, StUnpack, StSpecial, StNormalise, StSqrtIter, StRound, StPack, StPutZ
  } state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        a_q, a_d, z_q, z_d;
  logic [MW-1:0]       m_q, m_d, q_q, q_d;
  logic [EW-1:0]       e_q, e_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [EXP_W-1:0]    rexp_q, rexp_d;
  logic                inv_q, inv_d, inx_q, inx_d, a_ack_q, a_ack_d, z_stb_q, z_stb_d;

  logic                sign_f, exp_ones, exp_zero, frac_zero;
  logic [EXP_W-1:0]    exp_f;
  logic [FRAC_W-1:0]   frac_f;
  logic [RW-1:0]       tmp, trial;
  logic                guard, sticky, up, carry;
  logic [FRAC_W-1:0]   frac_sum;
  logic [EW-1:0]       exp_res;

  assign sign_f    = a_q[W-1];
  assign exp_f     = a_q[W-2:FRAC_W];
  assign frac_f    = a_q[FRAC_W-1:0];
  assign exp_ones  = &exp_f;
  assign exp_zero  = ~|exp_f;
  assign frac_zero = ~|frac_f;

  // One restoring step: bring down two radicand bits, try root*4+1.
  assign tmp   = {rem_q[RW-3:0], m_q[MW-1:MW-2]};
  assign trial = {1'b0, q_q, 2'b01};

  assign guard  = q_q[0];
  assign sticky = |rem_q;
  assign up     = guard & (sticky | q_q[1]);
  assign {carry, frac_sum} = {1'b0, q_q[FRAC_W:1]} + {{FRAC_W{1'b0}}, up};
  assign exp_res = {e_q[EW-1], e_q[EW-1:1]} + Bias + {{(EW-1){1'b0}}, carry};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    z_d     = z_q;
    m_d     = m_q;
    q_d     = q_q;
    e_d     = e_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    frac_d  = frac_q;
    rexp_d  = rexp_q;
    inv_d   = inv_q;
    inx_d   = inx_q;
    unique case (state_q)
      StGetA: begin
        if (input_a_stb && a_ack_q) begin
          a_d     = input_a;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        m_d     = {1'b0, ~exp_zero, frac_f};
        e_d     = (exp_zero ? EW'(1) : {2'b00, exp_f}) - Bias;
        state_d = StSpecial;
      end
      StSpecial: begin
        inv_d   = 1'b0;
        inx_d   = 1'b0;
        state_d = StPutZ;
        if (exp_ones && !frac_zero) begin
          z_d   = QNan;
          inv_d = ~frac_f[FRAC_W-1];
        end else if (exp_zero && frac_zero) begin
          z_d = a_q;
        end else if (sign_f) begin
          z_d   = QNan;
          inv_d = 1'b1;
        end else if (exp_ones) begin
          z_d = a_q;
        end else begin
          state_d = StNormalise;
        end
      end
      StNormalise: begin
        if (!m_q[FRAC_W]) begin
          m_d = {m_q[MW-2:0], 1'b0};
          e_d = e_q - EW'(1);
        end else begin
          // Make the exponent even so it halves exactly.
          if (e_q[0]) begin
            m_d = {m_q[MW-2:0], 1'b0};
            e_d = e_q - EW'(1);
          end
          q_d     = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StSqrtIter;
        end
      end
      StSqrtIter: begin
        if (tmp >= trial) begin
          rem_d = tmp - trial;
          q_d   = {q_q[MW-2:0], 1'b1};
        end else begin
          rem_d = tmp;
          q_d   = {q_q[MW-2:0], 1'b0};
        end
        m_d   = {m_q[MW-3:0], 2'b00};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FRAC_W + 1)) state_d = StRound;
      end
      StRound: begin
        frac_d  = frac_sum;
        rexp_d  = exp_res[EXP_W-1:0];
        inx_d   = guard | sticky;
        inv_d   = 1'b0;
        state_d = StPack;
      end
      StPack: begin
        z_d     = {1'b0, rexp_q, frac_q};
        state_d = StPutZ;
      end
      StPutZ: begin
        if (output_z_ack && z_stb_q) state_d = StGetA;
      end
      default: state_d = StGetA;
    endcase
    a_ack_d = (state_d == StGetA);
    z_stb_d = (state_d == StPutZ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StGetA;
      a_q     <= '0;
      z_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      e_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      frac_q  <= '0;
      rexp_q  <= '0;
      inv_q   <= 1'b0;
      inx_q   <= 1'b0;
      a_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      z_q     <= z_d;
      m_q     <= m_d;
      q_q     <= q_d;
      e_q     <= e_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      frac_q  <= frac_d;
      rexp_q  <= rexp_d;
      inv_q   <= inv_d;
      inx_q   <= inx_d;
      a_ack_q <= a_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

  assign input_a_ack    = a_ack_q;
  assign output_z_stb   = z_stb_q;
  assign output_z       = z_q;
  assign output_invalid = inv_q;
  assign output_inexact = inx_q;

endmodule
